// File: rtl/cam_pkg.sv
// Shared camera-path definitions: FSM state encoding, 44-bit FIFO word layout
// and default active frame size.
package cam_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned V_ACTIVE_DEF = 480;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned WORD_W  = 44;

    localparam int unsigned X_MSB = 43;
    localparam int unsigned X_LSB = 34;
    localparam int unsigned Y_MSB = 33;
    localparam int unsigned Y_LSB = 24;
    localparam int unsigned R_MSB = 23;
    localparam int unsigned R_LSB = 16;
    localparam int unsigned G_MSB = 15;
    localparam int unsigned G_LSB = 8;
    localparam int unsigned B_MSB = 7;
    localparam int unsigned B_LSB = 0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FRAME = 2'd1;
    localparam logic [1:0] S_LINE  = 2'd2;

    function automatic logic [WORD_W-1:0] pack_word(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y,
        input logic [7:0]         r,
        input logic [7:0]         g,
        input logic [7:0]         b
    );
        logic [WORD_W-1:0] w;
        w              = '0;
        w[X_MSB:X_LSB] = x;
        w[Y_MSB:Y_LSB] = y;
        w[R_MSB:R_LSB] = r;
        w[G_MSB:G_LSB] = g;
        w[B_MSB:B_LSB] = b;
        return w;
    endfunction

endpackage

// File: rtl/pix_coord_counter.sv
// Pixel position tracking for the packer: x within the line, y within the frame,
// both saturating at the active window size; also decides pixel acceptance.
module pix_coord_counter
    import cam_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic               line_start,
    input  logic               line_end,
    input  logic               pix_valid,
    output logic               accept,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y
);

    localparam logic [COORD_W-1:0] X_LIM = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(V_ACTIVE);

    assign accept = pix_valid & (x < X_LIM) & (y < Y_LIM);

    // x != 0 at line end means the line had at least one accepted pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (frame_start) begin
            x <= '0;
            y <= '0;
        end else begin
            if (line_start) begin
                x <= '0;
            end else if (accept) begin
                x <= x + COORD_W'(1);
            end
            if (line_end && (x != '0) && (y < Y_LIM)) begin
                y <= y + COORD_W'(1);
            end
        end
    end

endmodule

// File: rtl/ccd_pixel_packer.sv
// CCD-to-FIFO pixel packer: tracks frames/lines from fval/lval and writes one
// 44-bit word per accepted pixel. Define PACKER_DROP_CNT_EN for the drop_cnt port.
module ccd_pixel_packer
    import cam_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic              clk_25,
    input  logic              rst_n,
    input  logic              fval,
    input  logic              lval,
    input  logic              dval,
    input  logic [7:0]        pix_r,
    input  logic [7:0]        pix_g,
    input  logic [7:0]        pix_b,
    input  logic              wrfull,
    output logic [WORD_W-1:0] data,
    output logic              wrreq,
    output logic              wrclk,
    output logic              frame_done,
    output logic              overflow
`ifdef PACKER_DROP_CNT_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic               fval_d;
    logic               fval_rise;
    logic               frame_start;
    logic               line_start;
    logic               line_end;
    logic               frame_end;
    logic               pix_valid;
    logic               accept;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;

    assign wrclk       = clk_25;
    assign fval_rise   = fval & ~fval_d;
    assign frame_start = (state == S_IDLE) & fval_rise;
    assign line_start  = (state == S_FRAME) & fval & lval;
    assign line_end    = (state == S_LINE) & fval & ~lval;
    assign frame_end   = (state != S_IDLE) & ~fval;
    assign pix_valid   = (state == S_LINE) & lval & dval;

    pix_coord_counter #(
        .H_ACTIVE(H_ACTIVE),
        .V_ACTIVE(V_ACTIVE)
    ) u_coord (
        .clk        (clk_25),
        .rst_n      (rst_n),
        .frame_start(frame_start),
        .line_start (line_start),
        .line_end   (line_end),
        .pix_valid  (pix_valid),
        .accept     (accept),
        .x          (x),
        .y          (y)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (fval_rise) state_nxt = S_FRAME;
            S_FRAME: begin
                if (!fval)     state_nxt = S_IDLE;
                else if (lval) state_nxt = S_LINE;
            end
            S_LINE: begin
                if (!fval)      state_nxt = S_IDLE;
                else if (!lval) state_nxt = S_FRAME;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // fval_d resets high so a frame already in progress at reset release is skipped.
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            fval_d <= 1'b1;
        end else begin
            state  <= state_nxt;
            fval_d <= fval;
        end
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            wrreq      <= 1'b0;
            data       <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            wrreq      <= accept & ~wrfull;
            frame_done <= frame_end;
            if (accept && !wrfull) begin
                data <= pack_word(x, y, pix_r, pix_g, pix_b);
            end
            if (frame_start) begin
                overflow <= 1'b0;
            end else if (accept && wrfull) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef PACKER_DROP_CNT_EN
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (accept && wrfull && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule
